// File: rtl/i2c_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_xfer_sequencer
//   Bit/byte sequencer for the I2C byte engine. It counts the data bits of each
//   byte (MSB first), inserts an ACK slot after every byte and counts the bytes
//   of a transfer. It also flags byte completion, last byte, NACK and the end
//   of the transfer. BitTick comes from the SCL timing generator. The phase and
//   status flags feed the shift-register/control FSM.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Start      in   1-cycle pulse, begins a transfer when idle
//   NumBytes   in   bytes to transfer, sampled when Start is accepted
//   BitTick    in   1-cycle pulse per completed SCL bit (data or ACK slot)
//   AckIn      in   SDA sampled in the ACK slot (0=ACK, 1=NACK)
//   Abort      in   synchronous abort, highest priority
//   Busy       out  state is DATA or ACK
//   DataPhase  out  state is DATA
//   AckPhase   out  state is ACK
//   BitIdx     out  current data bit index, DATA_BITS-1 down to 0
//   BitZero    out  last data bit of the byte
//   BytesLeft  out  bytes remaining, including the current one
//   LastByte   out  current byte is the final one
//   ByteDone   out  1-cycle pulse: ACK slot completed
//   Nack       out  1-cycle pulse: NACK received
//   XferDone   out  1-cycle pulse: transfer ended (normally or by NACK)
// -----------------------------------------------------------------------------
module i2c_xfer_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int BYTE_CNT_W = 8,
  localparam int BIT_W     = $clog2(DATA_BITS)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [BYTE_CNT_W-1:0] NumBytes,
  input  logic                  BitTick,
  input  logic                  AckIn,
  input  logic                  Abort,
  output logic                  Busy,
  output logic                  DataPhase,
  output logic                  AckPhase,
  output logic [BIT_W-1:0]      BitIdx,
  output logic                  BitZero,
  output logic [BYTE_CNT_W-1:0] BytesLeft,
  output logic                  LastByte,
  output logic                  ByteDone,
  output logic                  Nack,
  output logic                  XferDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [BIT_W-1:0]      BIT_TOP  = BIT_W'(DATA_BITS - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_ONE = BYTE_CNT_W'(1);

  state_t                r_state;
  logic [BIT_W-1:0]      r_bit_idx;
  logic [BYTE_CNT_W-1:0] r_bytes_left;
  logic                  r_byte_done;
  logic                  r_nack;
  logic                  r_xfer_done;

  // NOTE: every register here is assigned with <=. All of them then sample the
  // same pre-edge values, whatever order the statements are written in.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= IDLE;
      r_bit_idx    <= '0;
      r_bytes_left <= '0;
      r_byte_done  <= 1'b0;
      r_nack       <= 1'b0;
      r_xfer_done  <= 1'b0;
    end else begin
      // The pulses default low, so each one lasts exactly one cycle.
      r_byte_done <= 1'b0;
      r_nack      <= 1'b0;
      r_xfer_done <= 1'b0;

      if (Abort) begin
        r_state      <= IDLE;
        r_bit_idx    <= '0;
        r_bytes_left <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            // Start is only looked at here. A Start in the cycle the FSM
            // leaves DATA/ACK is therefore dropped.
            if (Start) begin
              if (NumBytes != '0) begin
                r_state      <= DATA;
                r_bit_idx    <= BIT_TOP;
                r_bytes_left <= NumBytes;
              end else begin
                r_xfer_done  <= 1'b1;
              end
            end
          end

          DATA: begin
            if (BitTick) begin
              if (r_bit_idx != '0) r_bit_idx <= r_bit_idx - 1'b1;
              else                 r_state   <= ACK;
            end
          end

          ACK: begin
            if (BitTick) begin
              r_byte_done <= 1'b1;
              if (AckIn) begin
                // On a NACK, BytesLeft keeps the count of unacknowledged bytes.
                r_nack      <= 1'b1;
                r_xfer_done <= 1'b1;
                r_state     <= IDLE;
              end else if (r_bytes_left == BYTE_ONE) begin
                r_bytes_left <= '0;
                r_xfer_done  <= 1'b1;
                r_state      <= IDLE;
              end else begin
                r_bytes_left <= r_bytes_left - 1'b1;
                r_bit_idx    <= BIT_TOP;
                r_state      <= DATA;
              end
            end
          end

          default: begin
            r_state      <= IDLE;
            r_bit_idx    <= '0;
            r_bytes_left <= '0;
          end
        endcase
      end
    end
  end

  assign Busy      = (r_state == DATA) || (r_state == ACK);
  assign DataPhase = (r_state == DATA);
  assign AckPhase  = (r_state == ACK);
  assign BitIdx    = r_bit_idx;
  assign BitZero   = DataPhase && (r_bit_idx == '0);
  assign BytesLeft = r_bytes_left;
  assign LastByte  = Busy && (r_bytes_left == BYTE_ONE);
  assign ByteDone  = r_byte_done;
  assign Nack      = r_nack;
  assign XferDone  = r_xfer_done;

endmodule

// File: doc/i2c_xfer_sequencer.md
Name: i2c_xfer_sequencer

Overview:
Parametrised bit/byte sequencer for the I2C byte engine. It counts data bits per byte and bytes per transfer, inserts the ACK slot after each byte, and flags byte completion, last byte, NACK and transfer completion. It sits between the SCL timing generator, which supplies BitTick, and the shift-register/control FSM, which consumes the phase and status flags.

Parameters:
DATA_BITS, 8, data bits per byte (>=2); BIT_W = $clog2(DATA_BITS) derived localparam
BYTE_CNT_W, 8, width of byte counter; max transfer = 2^BYTE_CNT_W-1 bytes

Ports:
Clk  input  1  system clock, all state on rising edge
Rst_n  input  1  asynchronous, active-low reset
Start  input  1  1-cycle pulse; begins transfer when idle
NumBytes  input  BYTE_CNT_W  bytes to transfer, sampled when Start accepted
BitTick  input  1  1-cycle pulse per completed SCL bit (data or ACK slot)
AckIn  input  1  SDA value sampled in ACK slot (0=ACK, 1=NACK), valid with BitTick in ACK phase
Abort  input  1  synchronous abort, highest priority
Busy  output  1  transfer in progress (state DATA or ACK)
DataPhase  output  1  state == DATA
AckPhase  output  1  state == ACK
BitIdx  output  BIT_W  current data bit index, MSB first (DATA_BITS-1 down to 0)
BitZero  output  1  DataPhase && BitIdx==0 (last data bit of byte)
BytesLeft  output  BYTE_CNT_W  bytes remaining, including current
LastByte  output  1  Busy && BytesLeft==1
ByteDone  output  1  registered 1-cycle pulse: ACK slot completed
Nack  output  1  registered 1-cycle pulse: NACK received
XferDone  output  1  registered 1-cycle pulse: transfer ended (normally or by NACK)

Behaviour:
- Reset (Rst_n=0, async): state IDLE, BitIdx=0, BytesLeft=0, all pulses 0; all outputs 0.
- States: IDLE, DATA, ACK. Outputs Busy/DataPhase/AckPhase/BitZero/LastByte are combinational from registers.
- Priority each cycle: Abort > Start > BitTick.
- IDLE: Start && NumBytes!=0 -> DATA next cycle, BitIdx=DATA_BITS-1, BytesLeft=NumBytes. Start && NumBytes==0 -> stay IDLE, XferDone pulse next cycle. BitTick and AckIn ignored.
- DATA: BitTick with BitIdx!=0 -> BitIdx-1. BitTick with BitIdx==0 -> ACK (BitIdx stays 0).
- ACK: on BitTick, ByteDone pulses next cycle.
  - AckIn=1: Nack and XferDone pulse; -> IDLE; BytesLeft unchanged (it retains the count of bytes not fully acknowledged, including the current byte).
  - AckIn=0 && BytesLeft==1: BytesLeft=0, XferDone pulse, -> IDLE.
  - AckIn=0 && BytesLeft>1: BytesLeft-1, BitIdx=DATA_BITS-1, -> DATA.
- Start while Busy: ignored, no state change.
- Abort in any state: -> IDLE, BitIdx=0, BytesLeft=0, no pulses generated that cycle. Pending pulse outputs from the previous cycle still complete their single cycle.
- Abort and Start in the same cycle: Abort wins, Start is discarded.
- Pulse latency: ByteDone/Nack/XferDone are high exactly the one cycle after the triggering edge and never stretch.
- Back-to-back BitTick on consecutive cycles is legal. Each BitTick advances exactly one step.
- Arithmetic: counters never wrap. BitIdx decrements only when non-zero. BytesLeft decrements only in ACK with ACK received.
- No new transfer accepted in the cycle the FSM returns to IDLE. Start is accepted from the next cycle on.

Test Plan:
- Reset mid-transfer: NumBytes=3, 4 BitTicks, then Rst_n low -> all outputs 0 immediately, IDLE after release.
- DATA_BITS=8, NumBytes=2, all ACK (AckIn=0), 18 BitTicks -> BitIdx 7..0 twice. ByteDone pulses after ticks 9 and 18. LastByte high during the 2nd byte. Single XferDone after tick 18, Busy=0.
- NumBytes=3, AckIn=1 on first ACK slot (tick 9) -> ByteDone, Nack and XferDone pulse together the cycle after. IDLE, BytesLeft=3.
- Start with NumBytes=0 -> XferDone pulse 1 cycle later, Busy stays 0. Start while Busy -> BitIdx/BytesLeft unaffected.
- Abort asserted with Start, and separately during ACK phase with BitTick -> IDLE, BytesLeft=0, no ByteDone/XferDone.
- DATA_BITS=9, BYTE_CNT_W=4, NumBytes=15, all ACK -> BitIdx counts 8..0 per byte. 150 BitTicks total, 15 ByteDone pulses, 1 XferDone.
